mem_stage: RTL

- Memory stage directly downstream of the execution stage. Holds the EX/MM pipeline register and performs loads and stores through a variable-latency req/ack data-memory port.
- Drives the forwarding values (pval_mm, rval_mm, fval_mm) back to the EX operand muxes and a stall to upstream stages.
- Produces the MM/WB register consumed by writeback.

---
 rtl/mem_stage_pkg.sv | 30 +++
 rtl/mem_stage_fsm.sv | 86 ++++++++
 rtl/mem_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: control bit positions,
// writeback kinds and access FSM state encoding.
package mem_stage_pkg;

  localparam int DST_W_DEF = 5;

  localparam int MM_LD = 0;
  localparam int MM_ST = 1;

  localparam logic [1:0] WB_NONE = 2'b00;
  localparam logic [1:0] WB_P    = 2'b01;
  localparam logic [1:0] WB_I    = 2'b10;
  localparam logic [1:0] WB_F    = 2'b11;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } mm_state_e;

  // A memory op is unusable if it is both load and store or misaligned.
  function automatic logic mem_bad(
    input logic [3:0] mm,
    input logic [1:0] lsb
  );
    logic is_mem;
    is_mem = mm[MM_LD] | mm[MM_ST];
    return is_mem & ((mm[MM_LD] & mm[MM_ST]) | (lsb != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_fsm.sv
// Data-memory access sequencer: request, ack wait, timeout and fault.
// Owns the request line and the stall seen by upstream stages.
module mem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic bad_i,
  input  logic ack_i,
  output logic busy_o,
  output logic req_o,
  output logic done_o,
  output logic abort_o,
  output logic fault_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mm_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          fault_q, fault_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    fault_d = 1'b0;
    done_o  = 1'b0;
    abort_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        fault_d = bad_i;
        if (start_i) begin
          state_d = S_ACCESS;
          req_d   = 1'b1;
        end
      end
      S_ACCESS: begin
        if (ack_i) begin
          done_o  = 1'b1;
          state_d = S_IDLE;
          req_d   = 1'b0;
          cnt_d   = '0;
        // The edge that would bring the count to TIMEOUT aborts.
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          abort_o = 1'b1;
          fault_d = 1'b1;
          state_d = S_IDLE;
          req_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o  = (state_q == S_ACCESS);
  assign req_o   = req_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MM and MM/WB registers around the
// req/ack data-memory port, with forwarding back to EX.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int DST_W   = DST_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       MM,
  input  logic [DST_W-1:0] dst,
  input  logic             result_P,
  input  logic [31:0]      result_I,
  input  logic [31:0]      result_F,
  input  logic [31:0]      Wdata,
  output logic             stall_mm,
  output logic             pval_mm,
  output logic [31:0]      rval_mm,
  output logic [31:0]      fval_mm,
  output logic             fwd_ok,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  input  logic             dmem_ack,
  input  logic [31:0]      dmem_rdata,
  output logic             wb_valid,
  output logic [1:0]       wb_kind,
  output logic [DST_W-1:0] wb_dst,
  output logic             wb_P,
  output logic [31:0]      wb_I,
  output logic [31:0]      wb_F,
  output logic             fault
);

  logic             ex_v_q, ex_bad_q;
  logic [3:0]       ex_mm_q;
  logic [DST_W-1:0] ex_dst_q;
  logic             ex_p_q;
  logic [31:0]      ex_i_q, ex_f_q, ex_wd_q;

  logic             wb_v_q, wb_p_q;
  logic [1:0]       wb_kind_q;
  logic [DST_W-1:0] wb_dst_q;
  logic [31:0]      wb_i_q, wb_f_q;

  logic cap, bad_in, start, busy, done, abort;
  logic ex_v_d, wb_v_d, wb_ld;

  assign cap    = in_valid & ~stall_mm;
  assign bad_in = mem_bad(MM, result_I[1:0]);
  assign start  = cap & (MM[MM_LD] | MM[MM_ST]) & ~bad_in;

  mem_access_fsm #(
    .TIMEOUT(TIMEOUT)
  ) u_fsm (
    .clk    (clk),
    .rst    (rst),
    .start_i(start),
    .bad_i  (cap & bad_in),
    .ack_i  (dmem_ack),
    .busy_o (busy),
    .req_o  (dmem_req),
    .done_o (done),
    .abort_o(abort),
    .fault_o(fault)
  );

  // Non-memory and faulting ops leave MM on the edge after capture.
  assign ex_v_d = cap ? 1'b1 :
                  busy ? (ex_v_q & ~(done | abort)) : 1'b0;
  assign wb_v_d = (~busy & ex_v_q & ~ex_bad_q) | done;
  assign wb_ld  = (~busy & ex_v_q) | done | abort;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_v_q    <= 1'b0;
      ex_bad_q  <= 1'b0;
      ex_mm_q   <= '0;
      ex_dst_q  <= '0;
      ex_p_q    <= 1'b0;
      ex_i_q    <= '0;
      ex_f_q    <= '0;
      ex_wd_q   <= '0;
      wb_v_q    <= 1'b0;
      wb_kind_q <= WB_NONE;
      wb_dst_q  <= '0;
      wb_p_q    <= 1'b0;
      wb_i_q    <= '0;
      wb_f_q    <= '0;
    end else begin
      ex_v_q <= ex_v_d;
      if (cap) begin
        ex_bad_q <= bad_in;
        ex_mm_q  <= MM;
        ex_dst_q <= dst;
        ex_p_q   <= result_P;
        ex_i_q   <= result_I;
        ex_f_q   <= result_F;
        ex_wd_q  <= Wdata;
      end
      wb_v_q <= wb_v_d;
      if (wb_ld) begin
        wb_kind_q <= ex_mm_q[3:2];
        wb_dst_q  <= ex_dst_q;
        wb_p_q    <= ex_p_q;
        wb_i_q    <= (done & ex_mm_q[MM_LD]) ? dmem_rdata : ex_i_q;
        wb_f_q    <= ex_f_q;
      end
    end
  end

  assign stall_mm   = busy;
  assign fwd_ok     = ~(busy & ex_mm_q[MM_LD]);
  assign pval_mm    = ex_p_q;
  assign rval_mm    = ex_i_q;
  assign fval_mm    = ex_f_q;
  assign dmem_we    = dmem_req & ex_mm_q[MM_ST];
  assign dmem_addr  = ex_i_q;
  assign dmem_wdata = ex_wd_q;

  assign wb_valid = wb_v_q;
  assign wb_kind  = wb_kind_q;
  assign wb_dst   = wb_dst_q;
  assign wb_P     = wb_p_q;
  assign wb_I     = wb_i_q;
  assign wb_F     = wb_f_q;

endmodule
